// File: rtl/target_readout_arbiter.sv
// Double-buffered target-table snapshot on vsync with round-robin streamed readout.
// Build macro TARGET_READOUT_SKIP_INVALID_EN: streams carry only valid entries.
module target_readout_arbiter #(
    parameter int unsigned NUM_TARGETS   = 4,
    parameter int unsigned SCREEN_WIDTH  = 1280,
    parameter int unsigned SCREEN_HEIGHT = 720,
    parameter int unsigned NUM_REQ       = 2,
    localparam int unsigned TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
    localparam int unsigned XW = $clog2(SCREEN_WIDTH),
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT) + 1,
    localparam int unsigned RW = $clog2(NUM_REQ)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      vsync_in,
    input  logic [NUM_TARGETS*XW-1:0] tgt_x_in,
    input  logic [NUM_TARGETS*YW-1:0] tgt_y_in,
    input  logic [NUM_TARGETS*YW-1:0] tgt_d_in,
    input  logic [NUM_TARGETS-1:0]    tgt_valid_in,
    output logic                      det_rst_out,
    input  logic [NUM_REQ-1:0]        req_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    output logic                      rd_strobe_out,
    output logic [TW-1:0]             rd_idx_out,
    output logic [XW-1:0]             rd_x_out,
    output logic [YW-1:0]             rd_y_out,
    output logic [YW-1:0]             rd_d_out,
    output logic                      rd_valid_out,
    output logic                      rd_last_out,
    output logic [7:0]                frame_id_out,
    output logic [7:0]                drop_cnt_out
);

    typedef enum logic {StIdle, StStream} state_e;

    state_e state_q, state_d;
    logic vsync_q, det_rst_q, det_rst_d;
    logic front_q, front_d, pending_q, pending_d;
    logic [7:0] back_fid_q, back_fid_d, frame_id_q, frame_id_d, drop_q, drop_d;
    logic [NUM_TARGETS*XW-1:0] bank_x_q [2];
    logic [NUM_TARGETS*XW-1:0] bank_x_d [2];
    logic [NUM_TARGETS*YW-1:0] bank_y_q [2];
    logic [NUM_TARGETS*YW-1:0] bank_y_d [2];
    logic [NUM_TARGETS*YW-1:0] bank_dm_q [2];
    logic [NUM_TARGETS*YW-1:0] bank_dm_d [2];
    logic [NUM_TARGETS-1:0]    bank_v_q [2];
    logic [NUM_TARGETS-1:0]    bank_v_d [2];
    logic [RW-1:0] rr_q, rr_d, arb_idx;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic rd_strobe_q, rd_strobe_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [TW-1:0] rd_idx_q, rd_idx_d;
    logic [XW-1:0] rd_x_q, rd_x_d;
    logic [YW-1:0] rd_y_q, rd_y_d, rd_d_q, rd_d_d;
    logic vsync_edge, do_swap, arb_found, load, sel_found, sel_last;
    int   start_idx, sel_idx, cand;

    assign vsync_edge = vsync_in & ~vsync_q;
    // The front pointer only moves while no stream is reading it.
    assign do_swap    = (state_q == StIdle) && pending_q;
    assign det_rst_d  = vsync_edge;

    always_comb begin
        front_d    = front_q;
        pending_d  = pending_q;
        back_fid_d = back_fid_q;
        frame_id_d = frame_id_q;
        drop_d     = drop_q;
        bank_x_d   = bank_x_q;
        bank_y_d   = bank_y_q;
        bank_dm_d  = bank_dm_q;
        bank_v_d   = bank_v_q;
        if (do_swap) begin
            front_d    = ~front_q;
            frame_id_d = back_fid_q;
            pending_d  = 1'b0;
        end
        if (vsync_edge) begin
            bank_x_d[~front_d]  = tgt_x_in;
            bank_y_d[~front_d]  = tgt_y_in;
            bank_dm_d[~front_d] = tgt_d_in;
            bank_v_d[~front_d]  = tgt_valid_in;
            back_fid_d          = back_fid_q + 8'd1;
            pending_d           = 1'b1;
            if (pending_q && !do_swap && drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_q;
        cand      = 0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = (int'(rr_q) + k) % int'(NUM_REQ);
            if (!arb_found && req_in[cand]) begin
                arb_found = 1'b1;
                arb_idx   = RW'(cand);
            end
        end
    end

    always_comb begin
        start_idx = (state_q == StIdle) ? 0 : int'(rd_idx_q) + 1;
        sel_found = 1'b0;
        sel_idx   = 0;
        sel_last  = 1'b1;
`ifdef TARGET_READOUT_SKIP_INVALID_EN
        for (int i = 0; i < int'(NUM_TARGETS); i++) begin
            if (bank_v_q[front_q][i]) begin
                if (!sel_found && i >= start_idx) begin
                    sel_found = 1'b1;
                    sel_idx   = i;
                end else if (sel_found) begin
                    sel_last = 1'b0;
                end
            end
        end
`else
        sel_found = 1'b1;
        sel_idx   = (start_idx < int'(NUM_TARGETS)) ? start_idx : 0;
        sel_last  = (sel_idx == int'(NUM_TARGETS) - 1);
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!pending_q && arb_found) state_d = StStream;
            StStream: if (rd_last_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        load        = 1'b0;
        rd_strobe_d = 1'b0;
        rd_idx_d    = '0;
        rd_x_d      = '0;
        rd_y_d      = '0;
        rd_d_d      = '0;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!pending_q && arb_found) begin
                    gnt_d = NUM_REQ'(1) << arb_idx;
                    rr_d  = arb_idx;
                    load  = 1'b1;
                end
            end
            StStream: begin
                if (rd_last_q) gnt_d = '0;
                else           load  = 1'b1;
            end
            default: gnt_d = '0;
        endcase
        if (load) begin
            rd_strobe_d = 1'b1;
            rd_idx_d    = TW'(sel_idx);
            rd_last_d   = sel_last;
            if (sel_found) begin
                rd_x_d     = bank_x_q[front_q][sel_idx*XW +: XW];
                rd_y_d     = bank_y_q[front_q][sel_idx*YW +: YW];
                rd_d_d     = bank_dm_q[front_q][sel_idx*YW +: YW];
                rd_valid_d = bank_v_q[front_q][sel_idx];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            vsync_q     <= 1'b0;
            det_rst_q   <= 1'b0;
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            back_fid_q  <= '0;
            frame_id_q  <= '0;
            drop_q      <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_x_q[b]  <= '0;
                bank_y_q[b]  <= '0;
                bank_dm_q[b] <= '0;
                bank_v_q[b]  <= '0;
            end
            rr_q        <= RW'(NUM_REQ - 1);
            gnt_q       <= '0;
            rd_strobe_q <= 1'b0;
            rd_idx_q    <= '0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_d_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_in;
            det_rst_q   <= det_rst_d;
            front_q     <= front_d;
            pending_q   <= pending_d;
            back_fid_q  <= back_fid_d;
            frame_id_q  <= frame_id_d;
            drop_q      <= drop_d;
            bank_x_q    <= bank_x_d;
            bank_y_q    <= bank_y_d;
            bank_dm_q   <= bank_dm_d;
            bank_v_q    <= bank_v_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            rd_strobe_q <= rd_strobe_d;
            rd_idx_q    <= rd_idx_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_d_q      <= rd_d_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign det_rst_out   = det_rst_q;
    assign gnt_out       = gnt_q;
    assign rd_strobe_out = rd_strobe_q;
    assign rd_idx_out    = rd_idx_q;
    assign rd_x_out      = rd_x_q;
    assign rd_y_out      = rd_y_q;
    assign rd_d_out      = rd_d_q;
    assign rd_valid_out  = rd_valid_q;
    assign rd_last_out   = rd_last_q;
    assign frame_id_out  = frame_id_q;
    assign drop_cnt_out  = drop_q;

endmodule

// File: tb/tb_target_readout_arbiter.sv
// Bench for target_readout_arbiter: expected stream entries are queued at request time and
// popped by a monitor on every rd_strobe_out.
module tb_target_readout_arbiter;

    localparam int NT = 4;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int NR = 2;
    localparam int TW = 2;

    typedef struct packed {
        logic [NT-1:0]    v;
        logic [NT*YW-1:0] d;
        logic [NT*YW-1:0] y;
        logic [NT*XW-1:0] x;
    } frame_t;

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [TW-1:0] idx;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [YW-1:0] d;
        logic          valid;
        logic          last;
    } entry_t;

    logic clk, rst_n, vsync;
    logic [NT*XW-1:0] tgt_x;
    logic [NT*YW-1:0] tgt_y, tgt_d;
    logic [NT-1:0] tgt_v;
    logic det_rst_out;
    logic [NR-1:0] req_in, gnt_out;
    logic rd_strobe_out, rd_valid_out, rd_last_out;
    logic [TW-1:0] rd_idx_out;
    logic [XW-1:0] rd_x_out;
    logic [YW-1:0] rd_y_out, rd_d_out;
    logic [7:0] frame_id_out, drop_cnt_out;

    int checks = 0;
    int errors = 0;
    entry_t exp_q[$];

    target_readout_arbiter #(
        .NUM_TARGETS  (NT),
        .SCREEN_WIDTH (1280),
        .SCREEN_HEIGHT(720),
        .NUM_REQ      (NR)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .vsync_in     (vsync),
        .tgt_x_in     (tgt_x),
        .tgt_y_in     (tgt_y),
        .tgt_d_in     (tgt_d),
        .tgt_valid_in (tgt_v),
        .det_rst_out  (det_rst_out),
        .req_in       (req_in),
        .gnt_out      (gnt_out),
        .rd_strobe_out(rd_strobe_out),
        .rd_idx_out   (rd_idx_out),
        .rd_x_out     (rd_x_out),
        .rd_y_out     (rd_y_out),
        .rd_d_out     (rd_d_out),
        .rd_valid_out (rd_valid_out),
        .rd_last_out  (rd_last_out),
        .frame_id_out (frame_id_out),
        .drop_cnt_out (drop_cnt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input int x0, x1, x2, x3, input int y0, y1, y2, y3,
                                  input int d0, d1, d2, d3, input logic [3:0] v);
        frame_t f;
        f.x = {XW'(x3), XW'(x2), XW'(x1), XW'(x0)};
        f.y = {YW'(y3), YW'(y2), YW'(y1), YW'(y0)};
        f.d = {YW'(d3), YW'(d2), YW'(d1), YW'(d0)};
        f.v = v;
        return f;
    endfunction

    function automatic int stream_len(input frame_t f);
        int n;
        n = 0;
`ifdef TARGET_READOUT_SKIP_INVALID_EN
        for (int i = 0; i < NT; i++) if (f.v[i]) n++;
        if (n == 0) n = 1;
`else
        n = NT;
`endif
        return n;
    endfunction

    task automatic push_frame(input frame_t f, input logic [NR-1:0] g);
        entry_t e;
        int last_i;
`ifdef TARGET_READOUT_SKIP_INVALID_EN
        last_i = -1;
        for (int i = 0; i < NT; i++) if (f.v[i]) last_i = i;
        if (last_i < 0) begin
            e = '0;
            e.gnt = g;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
`else
        last_i = NT - 1;
`endif
        for (int i = 0; i < NT; i++) begin
`ifdef TARGET_READOUT_SKIP_INVALID_EN
            if (!f.v[i]) continue;
`endif
            e.gnt   = g;
            e.idx   = TW'(i);
            e.x     = f.x[i*XW +: XW];
            e.y     = f.y[i*YW +: YW];
            e.d     = f.d[i*YW +: YW];
            e.valid = f.v[i];
            e.last  = (i == last_i);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        entry_t act, e;
        act.gnt = gnt_out;
        act.idx = rd_idx_out;
        act.x = rd_x_out;
        act.y = rd_y_out;
        act.d = rd_d_out;
        act.valid = rd_valid_out;
        act.last = rd_last_out;
        checks++;
        if (rd_strobe_out) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got idx=%0d gnt=%b with no entry expected",
                         rd_idx_out, gnt_out);
            end else begin
                e = exp_q.pop_front();
                if (act != e) begin
                    errors++;
                    $display("FAIL stream_entry: got gnt=%b idx=%0d x=%0d y=%0d d=%0d v=%b l=%b expected gnt=%b idx=%0d x=%0d y=%0d d=%0d v=%b l=%b",
                             act.gnt, act.idx, act.x, act.y, act.d, act.valid, act.last,
                             e.gnt, e.idx, e.x, e.y, e.d, e.valid, e.last);
                end
            end
        end else if ({act.idx, act.x, act.y, act.d, act.valid, act.last} != '0) begin
            errors++;
            $display("FAIL rd_idle_zero: got idx=%0d x=%0d y=%0d d=%0d v=%b l=%b expected all 0",
                     act.idx, act.x, act.y, act.d, act.valid, act.last);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input frame_t f);
        tgt_x = f.x;
        tgt_y = f.y;
        tgt_d = f.d;
        tgt_v = f.v;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && gnt_out == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stream_drain_timeout", ok, 1);
    endtask

    task automatic do_stream(input logic [NR-1:0] mask, input logic [NR-1:0] g,
                             input frame_t f);
        push_frame(f, g);
        step();
        req_in = mask;
        step();
        req_in = '0;
        wait_idle();
    endtask

    initial begin
        frame_t zf, fa, fb, fc, fd1, fd2, fd3, fg;
        int n, cyc, nstart;
        int starts[3];
        logic [NR-1:0] prev_g;

        zf  = '0;
        fa  = mk(100, 0, 640, 0, 50, 0, 700, 0, 30, 0, 719, 0, 4'b0101);
        fb  = mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 4'b1010);
        fc  = mk(1279, 500, 20, 7, 719, 1, 360, 2, 3, 4, 5, 6, 4'b1111);
        fd1 = mk(11, 12, 13, 14, 21, 22, 23, 24, 31, 32, 33, 34, 4'b1111);
        fd2 = mk(41, 42, 43, 44, 51, 52, 53, 54, 61, 62, 63, 64, 4'b1111);
        fd3 = mk(0, 900, 1023, 0, 0, 100, 200, 0, 0, 40, 41, 0, 4'b0110);
        fg  = mk(77, 77, 77, 77, 33, 33, 33, 33, 22, 22, 22, 22, 4'b1001);

        rst_n = 1'b0;
        vsync = 1'b0;
        req_in = '0;
        apply(zf);
        repeat (3) @(negedge clk);
        chk("reset_gnt", gnt_out, 0);
        chk("reset_frame_id", frame_id_out, 0);
        chk("reset_drop", drop_cnt_out, 0);
        chk("reset_det_rst", det_rst_out, 0);
        chk("reset_strobe", rd_strobe_out, 0);
        step();
        rst_n = 1'b1;

        // Empty front bank before any frame.
        do_stream(2'b01, 2'b01, zf);
        chk("t1_frame_id", frame_id_out, 0);

        // Snapshot frame A, then change detector inputs.
        step();
        apply(fa);
        vsync = 1'b1;
        @(negedge clk);
        chk("t2_det_rst_at_edge", det_rst_out, 0);
        step();
        apply(fg);
        @(negedge clk);
        chk("t2_det_rst_e1", det_rst_out, 1);
        step();
        @(negedge clk);
        chk("t2_det_rst_e2", det_rst_out, 0);
        chk("t2_frame_id", frame_id_out, 1);
        do_stream(2'b01, 2'b01, fa);

        // Both requesters held: alternate grants, one idle cycle between streams.
        vsync = 1'b0;
        push_frame(fa, 2'b10);
        push_frame(fa, 2'b01);
        push_frame(fa, 2'b10);
        step();
        req_in = 2'b11;
        prev_g = '0;
        nstart = 0;
        for (cyc = 0; cyc < 100 && nstart < 3; cyc++) begin
            @(negedge clk);
            if (gnt_out != '0 && prev_g == '0) begin
                starts[nstart] = cyc;
                nstart++;
            end
            prev_g = gnt_out;
        end
        step();
        req_in = '0;
        wait_idle();
        chk("t3_stream_count", nstart, 3);
        n = stream_len(fa);
        chk("t3_gap_1", starts[1] - starts[0], n + 1);
        chk("t3_gap_2", starts[2] - starts[1], n + 1);

        // Edge during stream, second edge in the swap cycle: two back-to-back swaps.
        n = stream_len(fa);
        push_frame(fa, 2'b01);
        step();
        req_in = 2'b01;
        step();
        req_in = '0;
        vsync = 1'b1;
        apply(fb);
        step();
        vsync = 1'b0;
        apply(fg);
        repeat (n - 1) step();
        vsync = 1'b1;
        apply(fc);
        @(negedge clk);
        chk("t5_frame_id_swap_cycle", frame_id_out, 1);
        chk("t5_gnt_swap_cycle", gnt_out, 0);
        step();
        apply(fg);
        @(negedge clk);
        chk("t5_frame_id_first_swap", frame_id_out, 2);
        chk("t5_det_rst", det_rst_out, 1);
        step();
        @(negedge clk);
        chk("t5_frame_id_second_swap", frame_id_out, 3);
        chk("t5_drop_unchanged", drop_cnt_out, 0);
        do_stream(2'b10, 2'b10, fc);

        // Three edges around one stream: two overruns, swap blocked until idle.
        step();
        vsync = 1'b0;
        push_frame(fc, 2'b01);
        push_frame(fd3, 2'b01);
        step();
        req_in = 2'b01;
        vsync = 1'b1;
        apply(fd1);
        step();
        vsync = 1'b0;
        apply(fg);
        step();
        vsync = 1'b1;
        apply(fd2);
        step();
        vsync = 1'b0;
        apply(fg);
        @(negedge clk);
        chk("t4_drop_after_2nd_edge", drop_cnt_out, 1);
        step();
        vsync = 1'b1;
        apply(fd3);
        @(negedge clk);
        chk("t4_drop_before_3rd", drop_cnt_out, 1);
        step();
        apply(fg);
        @(negedge clk);
        chk("t4_drop_final", drop_cnt_out, 2);
        chk("t4_frame_id_pre_swap", frame_id_out, 3);
        chk("t4_gnt_swap_cycle", gnt_out, 0);
        step();
        @(negedge clk);
        chk("t4_frame_id_post_swap", frame_id_out, 6);
        step();
        req_in = '0;
        wait_idle();
        chk("t4_drop_held", drop_cnt_out, 2);

        // Asynchronous reset at the second strobe of a stream.
        push_frame(fd3, 2'b01);
        step();
        req_in = 2'b01;
        step();
        req_in = '0;
        @(negedge clk);
        step();
        rst_n = 1'b0;
        vsync = 1'b0;
        #1;
        chk("t6_rst_gnt", gnt_out, 0);
        chk("t6_rst_strobe", rd_strobe_out, 0);
        chk("t6_rst_frame_id", frame_id_out, 0);
        chk("t6_rst_drop", drop_cnt_out, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_frame_id", frame_id_out, 0);
        do_stream(2'b01, 2'b01, zf);
        chk("t6_post_stream_frame_id", frame_id_out, 0);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/target_readout_arbiter.md
# target_readout_arbiter

Frame-level controller for the marker-detection target table. It snapshots the detector's per-target results (centre x, row y, diameter, valid) on every vsync rising edge into a double-buffered store and pulses a one-cycle reset to the detector so the next frame starts clean. It serves the last completed frame to several consumers (e.g. overlay renderer, serial reporter) through a round-robin req/grant handshake that streams one target entry per cycle.

## Interface
- NUM_TARGETS, 4, target slots in the detector table; index width TW = max(1,$clog2(NUM_TARGETS))
- SCREEN_WIDTH, 1280, x range; XW = $clog2(SCREEN_WIDTH)
- SCREEN_HEIGHT, 720, y/diameter range; YW = $clog2(SCREEN_HEIGHT)+1
- NUM_REQ, 2, number of readout requesters (2..8)
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; one clock, reset is asynchronous and active-low
- vsync_in  input  1  frame boundary level from video timing
- tgt_x_in  input  NUM_TARGETS*XW  detector centres, entry i at [i*XW +: XW]
- tgt_y_in  input  NUM_TARGETS*YW  detector rows
- tgt_d_in  input  NUM_TARGETS*YW  detector diameters
- tgt_valid_in  input  NUM_TARGETS  detector valid flags
- det_rst_out  output  1  one-cycle active-high reset to the detector
- req_in  input  NUM_REQ  readout requests
- gnt_out  output  NUM_REQ  one-hot grant, held for whole stream
- rd_strobe_out  output  1  rd_* fields valid this cycle
- rd_idx_out  output  TW  target index of entry
- rd_x_out / rd_y_out / rd_d_out  output  XW / YW / YW  entry fields
- rd_valid_out  output  1  entry valid flag
- rd_last_out  output  1  final entry of stream
- frame_id_out  output  8  id of frame in front bank
- drop_cnt_out  output  8  saturating count of snapshots overwritten before use

## Operation
- Edge detect: vsync_d registers vsync_in; edge cycle E = vsync_in & ~vsync_d.
- Snapshot at end of E: back bank <= tgt_* inputs; det_rst_out <= 1 (exactly one cycle); back_frame_id <= back_frame_id+1 (wraps 255->0); swap_pending <= 1.
- Overrun: edge while swap_pending already 1 -> back bank overwritten, drop_cnt_out += 1 (saturates at 255).
- FSM IDLE/STREAM. Front-bank pointer changes only in IDLE.
- IDLE with swap_pending: swap banks, frame_id_out <= back_frame_id, clear swap_pending; no grant this cycle. If an edge also occurs this cycle, snapshot goes to the newly back bank and swap_pending stays 1.
- IDLE, no swap_pending, any req_in: grant first requester at or after rr_ptr+1 (mod NUM_REQ); rr_ptr <= granted index; -> STREAM.
- STREAM: one entry per cycle from front bank, ascending index; rd_last_out on final entry; then gnt_out drops and -> IDLE. Dropping req_in mid-stream does not abort.
- Before the first swap, front bank holds all-zero, invalid entries.

## Timing
- Reset: all outputs 0; banks zeroed/invalid; rr_ptr = NUM_REQ-1 (requester 0 highest priority); FSM IDLE; swap_pending 0.
- req_in sampled in IDLE cycle T -> gnt_out and first rd_strobe_out at T+1; last strobe at T+N (N entries streamed); gnt_out low at T+N+1; earliest next grant T+N+2.
- Snapshot of edge cycle E visible to a stream granted no earlier than E+2.
- rd_* outputs are registered; zero when rd_strobe_out is 0.
- Async reset mid-stream: immediate return to reset state, stream truncated without rd_last_out.

## Configuration
- TARGET_READOUT_SKIP_INVALID_EN defined: stream emits only entries with valid set, ascending index; if none valid, a single strobe with rd_idx_out=0, rd_valid_out=0, rd_last_out=1.
- Not defined: every stream emits all NUM_TARGETS entries, rd_valid_out per entry.

## Test plan
- Reset, req_in=01 before any vsync -> 4 strobes idx 0..3, all rd_valid_out=0, rd_last_out at idx 3, frame_id_out=0.
- Detector valid=0101, x={100,0,640,0}; vsync rise -> det_rst_out one cycle at E+1; request -> idx0 x=100 valid 1, idx2 x=640 valid 1, frame_id_out=1 (macro on: 2 strobes, idx 0 and 2, last on idx 2).
- req_in=11 held continuously -> grants alternate 01,10,01; each gnt_out lasts 4 cycles with one idle cycle between streams.
- Three vsync edges during one long stream chain (req held) such that swap is blocked -> drop_cnt_out=2, frame_id_out jumps to 3 after swap.
- Vsync edge in the IDLE cycle of a pending swap -> swap occurs, swap_pending remains 1, second swap next IDLE, drop_cnt_out unchanged.
- rst_n_in low at second strobe of a stream -> gnt_out, rd_strobe_out, frame_id_out, drop_cnt_out all 0 immediately; post-release request streams invalid entries.
